axi4_ram_slave: RTL and testbench



---
 rtl/axi4_pkg.sv | 25 ++
 rtl/axi4_ram_slave_mem.sv | 40 ++++
 rtl/axi4_ram_slave.sv | 216 +++++++++++++++++++++
 tb/tb_axi4_ram_slave.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and FSM state types for the on-chip RAM responder.
package axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_DRAIN,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi4_ram_slave_mem.sv
// Word-addressed memory: one synchronous write port, one asynchronous read port.
// Byte-lane enables are honoured only when AXI4_RAM_SLAVE_STRB_EN is defined.
module axi4_ram_slave_mem #(
    parameter int C_DATA_LEN = 128,
    parameter int C_STRB_LEN = C_DATA_LEN / 8,
    parameter int C_MEM_AW   = 12
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [C_MEM_AW-1:0]   i_waddr,
    input  logic [C_DATA_LEN-1:0] i_wdata,
    input  logic [C_STRB_LEN-1:0] i_wstrb,
    input  logic [C_MEM_AW-1:0]   i_raddr,
    output logic [C_DATA_LEN-1:0] o_rdata
);

    logic [C_STRB_LEN-1:0] w_be;

`ifdef AXI4_RAM_SLAVE_STRB_EN
    assign w_be = i_wstrb;
`else
    // Strobes are ignored in this build: every lane is always enabled.
    assign w_be = i_wstrb | {C_STRB_LEN{1'b1}};
`endif

    // One byte-wide array per lane so each lane has its own write enable.
    for (genvar gi = 0; gi < C_STRB_LEN; gi++) begin : g_lane
        logic [7:0] r_lane [0:(1<<C_MEM_AW)-1];

        // Lane write; contents are deliberately not reset.
        always_ff @(posedge i_clk) begin
            if (i_we && w_be[gi]) begin
                r_lane[i_waddr] <= i_wdata[gi*8 +: 8];
            end
        end

        assign o_rdata[gi*8 +: 8] = r_lane[i_raddr];
    end

endmodule

// File: rtl/axi4_ram_slave.sv
// AXI4 INCR-burst responder backed by on-chip memory. Independent write and
// read FSMs, one outstanding burst per direction.
// Optional macro: AXI4_RAM_SLAVE_STRB_EN enables per-byte write strobes.
module axi4_ram_slave
    import axi4_pkg::*;
#(
    parameter int          C_ID_LEN    = 8,
    parameter int          C_DATA_LEN  = 128,
    parameter int          C_DATA_SIZE = 4,
    parameter int          C_STRB_LEN  = C_DATA_LEN / 8,
    parameter int          C_MEM_AW    = 12,
    parameter logic [31:0] C_BASE_ADDR = 32'h00000000
) (
    input  logic                  axi_clk,
    input  logic                  axi_resetn,
    input  logic [C_ID_LEN-1:0]   axi_awid,
    input  logic [31:0]           axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic [2:0]            axi_awsize,
    input  logic [1:0]            axi_awburst,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [C_DATA_LEN-1:0] axi_wdata,
    input  logic [C_STRB_LEN-1:0] axi_wstrb,
    input  logic                  axi_wlast,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic [C_ID_LEN-1:0]   axi_bid,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    input  logic [C_ID_LEN-1:0]   axi_arid,
    input  logic [31:0]           axi_araddr,
    input  logic [7:0]            axi_arlen,
    input  logic [2:0]            axi_arsize,
    input  logic [1:0]            axi_arburst,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [C_ID_LEN-1:0]   axi_rid,
    output logic [C_DATA_LEN-1:0] axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rlast,
    output logic                  axi_rvalid,
    input  logic                  axi_rready
);

    localparam logic [C_MEM_AW-1:0] C_IDX_ONE = 1;

    // Burst is rejected for wrong size, non-INCR type, or an address outside the window.
    function automatic logic req_err(input logic [31:0] addr, input logic [2:0] size,
                                     input logic [1:0] burst);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, C_BASE_ADDR};
        return (size != 3'(C_DATA_SIZE)) || (burst != BURST_INCR) || off[32] ||
               ((off[31:0] >> (C_MEM_AW + C_DATA_SIZE)) != 32'd0);
    endfunction

    // Word index relative to the base address, wrapped to the memory depth.
    function automatic logic [C_MEM_AW-1:0] addr_idx(input logic [31:0] addr);
        return C_MEM_AW'((addr - C_BASE_ADDR) >> C_DATA_SIZE);
    endfunction

    wr_state_t             r_wstate;
    logic                  r_awready, r_wready, r_bvalid, r_werr;
    logic [C_ID_LEN-1:0]   r_bid;
    logic [1:0]            r_bresp;
    logic [C_MEM_AW-1:0]   r_widx;
    logic [8:0]            r_wcnt;

    rd_state_t             r_rstate;
    logic                  r_arready, r_rvalid, r_rlast, r_rerr;
    logic [C_ID_LEN-1:0]   r_rid;
    logic [1:0]            r_rresp;
    logic [C_DATA_LEN-1:0] r_rdata;
    logic [C_MEM_AW-1:0]   r_ridx;
    logic [8:0]            r_rcnt;

    logic                  w_mem_we;
    logic [C_DATA_LEN-1:0] w_mem_rdata;

    assign w_mem_we = (r_wstate == W_DATA) && r_wready && axi_wvalid && !r_werr;

    axi4_ram_slave_mem #(
        .C_DATA_LEN (C_DATA_LEN),
        .C_STRB_LEN (C_STRB_LEN),
        .C_MEM_AW   (C_MEM_AW)
    ) u_mem (
        .i_clk   (axi_clk),
        .i_we    (w_mem_we),
        .i_waddr (r_widx),
        .i_wdata (axi_wdata),
        .i_wstrb (axi_wstrb),
        .i_raddr (r_ridx),
        .o_rdata (w_mem_rdata)
    );

    // Write FSM: AW accept, data beats (with early/late wlast handling), B response.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= RESP_OKAY;
            r_widx    <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (axi_awvalid && r_awready) begin
                        r_bid     <= axi_awid;
                        r_widx    <= addr_idx(axi_awaddr);
                        r_wcnt    <= {1'b0, axi_awlen} + 9'd1;
                        r_werr    <= req_err(axi_awaddr, axi_awsize, axi_awburst);
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi_wvalid) begin
                        r_widx <= r_widx + C_IDX_ONE;
                        r_wcnt <= r_wcnt - 9'd1;
                        if (axi_wlast) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || (r_wcnt != 9'd1)) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end else if (r_wcnt == 9'd1) begin
                            r_wstate <= W_DRAIN;
                        end
                    end
                end
                W_DRAIN: begin
                    if (axi_wvalid && axi_wlast) begin
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= RESP_SLVERR;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: AR accept, then a skid-free output register refilled whenever it is free or consumed.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rerr    <= 1'b0;
            r_rid     <= '0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
            r_ridx    <= '0;
            r_rcnt    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (axi_arvalid && r_arready) begin
                        r_rid     <= axi_arid;
                        r_ridx    <= addr_idx(axi_araddr);
                        r_rcnt    <= {1'b0, axi_arlen} + 9'd1;
                        r_rerr    <= req_err(axi_araddr, axi_arsize, axi_arburst);
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if ((!r_rvalid || axi_rready) && (r_rcnt != 9'd0)) begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= r_rerr ? '0 : w_mem_rdata;
                        r_rresp  <= r_rerr ? RESP_SLVERR : RESP_OKAY;
                        r_rlast  <= (r_rcnt == 9'd1);
                        r_ridx   <= r_ridx + C_IDX_ONE;
                        r_rcnt   <= r_rcnt - 9'd1;
                    end else if (r_rvalid && axi_rready) begin
                        // Final beat consumed with nothing left to load.
                        r_rvalid  <= 1'b0;
                        r_rlast   <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign axi_awready = r_awready;
    assign axi_wready  = r_wready;
    assign axi_bvalid  = r_bvalid;
    assign axi_bid     = r_bid;
    assign axi_bresp   = r_bresp;
    assign axi_arready = r_arready;
    assign axi_rvalid  = r_rvalid;
    assign axi_rid     = r_rid;
    assign axi_rdata   = r_rdata;
    assign axi_rresp   = r_rresp;
    assign axi_rlast   = r_rlast;

endmodule

// File: tb/tb_axi4_ram_slave.sv
// Directed bench for axi4_ram_slave with a behavioural memory/response model.
module tb_axi4_ram_slave;
    import axi4_pkg::*;

    localparam int DW = 128;
    localparam int IW = 8;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [IW-1:0] awid, arid, bid, rid;
    logic [31:0]   awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [15:0]   wstrb;

    axi4_ram_slave dut (
        .axi_clk(clk), .axi_resetn(rst_n),
        .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize),
        .axi_awburst(awburst), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid),
        .axi_wready(wready),
        .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize),
        .axi_arburst(arburst), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast),
        .axi_rvalid(rvalid), .axi_rready(rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [DW-1:0] d; logic [1:0] resp; logic last; logic [IW-1:0] id; } rbeat_t;
    typedef struct { logic [IW-1:0] id; logic [1:0] resp; } bexp_t;

    logic [DW-1:0] model_mem [int];
    rbeat_t        exp_r [$];
    bexp_t         exp_b [$];
    logic [DW-1:0] got_r [$];
    bit            rr_random = 0;

    function automatic bit bad_req(input logic [31:0] addr, input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'd4) || (burst != BURST_INCR) || (addr >= 32'h0001_0000);
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'(addr >> 4) % DEPTH;
    endfunction

    function automatic void model_write(input int w, input logic [DW-1:0] d, input logic [15:0] strb);
        logic [DW-1:0] m, old;
        for (int b = 0; b < 16; b++) m[b*8 +: 8] = {8{strb[b]}};
`ifndef AXI4_RAM_SLAVE_STRB_EN
        m = m | {DW{1'b1}};   // strobes ignored in this build
`endif
        old = model_mem.exists(w) ? model_mem[w] : '0;
        model_mem[w] = (old & ~m) | (d & m);
    endfunction

    function automatic logic [DW-1:0] got_at(input int i);
        return (i < got_r.size()) ? got_r[i] : {DW{1'bx}};
    endfunction

    function automatic logic rdy(input int ch);
        case (ch)
            0:       return awready;
            1:       return wready;
            default: return arready;
        endcase
    endfunction

    // Wait until the ready of channel ch is seen high, then let the handshake edge pass.
    task automatic wait_hs(input int ch);
        int n = 0;
        @(negedge clk);
        while (!rdy(ch) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(ch)) chk($sformatf("hs_timeout_ch%0d", ch), DW'(rdy(ch)), 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("r_drain", DW'(exp_r.size()), 0);
        chk("b_drain", DW'(exp_b.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Write burst of nbeats beats (wlast on the last sent), data = base + beat number.
    task automatic axi_write(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                             input logic [DW-1:0] base, input logic [15:0] strb);
        bit    err = bad_req(addr, size, burst);
        int    nlen = int'(len) + 1;
        bexp_t b;
        b.id   = id;
        b.resp = (err || nbeats != nlen) ? RESP_SLVERR : RESP_OKAY;
        if (!err) for (int k = 0; k < nbeats && k < nlen; k++)
            model_write((word_of(addr) + k) % DEPTH, base + DW'(k), strb);
        exp_b.push_back(b);
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        wait_hs(0);
        awvalid = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            wdata = base + DW'(k); wstrb = strb; wlast = (k == nbeats - 1); wvalid = 1'b1;
            wait_hs(1);
        end
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge clk);
        chk("b_latency", DW'(bvalid), 1);
        $display("WRITE id=%h addr=%h len=%0d beats=%0d expect_bresp=%0d", id, addr, len, nbeats, b.resp);
    endtask

    task automatic axi_read(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        bit     err = bad_req(addr, size, burst);
        int     w = word_of(addr);
        rbeat_t e;
        got_r.delete();
        for (int k = 0; k <= int'(len); k++) begin
            e.d    = (err || !model_mem.exists((w + k) % DEPTH)) ? '0 : model_mem[(w + k) % DEPTH];
            e.resp = err ? RESP_SLVERR : RESP_OKAY;
            e.last = (k == int'(len));
            e.id   = id;
            exp_r.push_back(e);
        end
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        wait_hs(2);
        arvalid = 1'b0;
        @(negedge clk);
        chk("r_lat_cycle1", DW'(rvalid), 0);
        @(negedge clk);
        chk("r_lat_cycle2", DW'(rvalid), 1);
        wait_done();
        $display("READ  id=%h addr=%h len=%0d beats_seen=%0d", id, addr, len, got_r.size());
    endtask

    // rready driver: always high, or random while rr_random is set.
    initial begin
        rready = 1'b1;
        forever begin
            @(posedge clk); #1;
            rready = rr_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Per-cycle compare of B and R channels against the model queues.
    logic          p_v = 0, p_rdy = 0, p_last = 0, p_bhs = 0;
    logic [DW-1:0] p_d = '0;
    initial begin
        rbeat_t e;
        bexp_t  b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_v = 0; p_rdy = 0; p_last = 0; p_bhs = 0;
            end else begin
                if (p_v && !p_rdy) begin
                    chk("r_hold_valid", DW'(rvalid), 1);
                    chk("r_hold_data", rdata, p_d);
                    chk("r_hold_last", DW'(rlast), DW'(p_last));
                end
                if (p_v && p_rdy && p_last) chk("arready_after_rlast", DW'(arready), 1);
                if (p_v && p_rdy && !p_last && exp_r.size() != 0) chk("r_no_bubble", DW'(rvalid), 1);
                if (p_bhs) chk("awready_after_b", DW'(awready), 1);
                if (rvalid && rready) begin
                    if (exp_r.size() == 0) begin
                        chk("r_unexpected", DW'(rvalid), 0);
                    end else begin
                        e = exp_r.pop_front();
                        chk("rdata", rdata, e.d);
                        chk("rresp", DW'(rresp), DW'(e.resp));
                        chk("rlast", DW'(rlast), DW'(e.last));
                        chk("rid", DW'(rid), DW'(e.id));
                        got_r.push_back(rdata);
                    end
                end
                p_bhs = 0;
                if (bvalid && bready) begin
                    if (exp_b.size() == 0) begin
                        chk("b_unexpected", DW'(bvalid), 0);
                    end else begin
                        b = exp_b.pop_front();
                        chk("bid", DW'(bid), DW'(b.id));
                        chk("bresp", DW'(bresp), DW'(b.resp));
                        $display("BRESP id=%h resp=%0d", bid, bresp);
                    end
                    p_bhs = 1;
                end
                p_v = rvalid; p_rdy = rready; p_last = rlast; p_d = rdata;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    localparam logic [DW-1:0] PAT_A = 128'hA000_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [DW-1:0] ONES  = {16{8'h11}};
    localparam logic [DW-1:0] TWOS  = {16{8'h22}};

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 0;
        wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", DW'(awready), 0);
        chk("rst_wready", DW'(wready), 0);
        chk("rst_bvalid", DW'(bvalid), 0);
        chk("rst_arready", DW'(arready), 0);
        chk("rst_rvalid", DW'(rvalid), 0);
        chk("rst_rlast", DW'(rlast), 0);
        chk("rst_bid_rid", DW'({bid, rid, bresp, rresp}), 0);
        chk("rst_rdata", rdata, 0);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_awready", DW'(awready), 1);
        chk("idle_arready", DW'(arready), 1);

        // Basic 4-beat write/read
        axi_write(8'h5A, 32'h0, 8'd3, 3'd4, BURST_INCR, 4, 128'h1, 16'hFFFF);
        axi_read(8'h33, 32'h0, 8'd3, 3'd4, BURST_INCR);
        chk("lit_basic_cnt", DW'(got_r.size()), 4);
        chk("lit_basic_0", got_at(0), 128'h1);
        chk("lit_basic_3", got_at(3), 128'h4);

        // 128-beat burst, read back with random rready
        axi_write(8'h01, 32'h1000, 8'd127, 3'd4, BURST_INCR, 128, PAT_A, 16'hFFFF);
        rr_random = 1;
        axi_read(8'h02, 32'h1000, 8'd127, 3'd4, BURST_INCR);
        rr_random = 0;
        chk("lit_long_cnt", DW'(got_r.size()), 128);
        chk("lit_long_0", got_at(0), PAT_A);
        chk("lit_long_127", got_at(127), PAT_A + 128'h7F);

        // Bad size write: nothing written; FIXED and out-of-range reads return zero SLVERR
        axi_write(8'h03, 32'h10, 8'd0, 3'd3, BURST_INCR, 1, 128'hDEAD, 16'hFFFF);
        axi_read(8'h04, 32'h10, 8'd0, 3'd4, BURST_INCR);
        chk("lit_size_err_kept", got_at(0), 128'h2);
        axi_read(8'h05, 32'h0, 8'd3, 3'd4, BURST_FIXED);
        chk("lit_fixed_cnt", DW'(got_r.size()), 4);
        chk("lit_fixed_zero", got_at(2), 128'h0);
        axi_read(8'h06, 32'h0001_0000, 8'd0, 3'd4, BURST_INCR);

        // Early wlast (len 3, wlast on beat 2)
        axi_write(8'h07, 32'h100, 8'd3, 3'd4, BURST_INCR, 4, 128'h100, 16'hFFFF);
        axi_write(8'h08, 32'h100, 8'd3, 3'd4, BURST_INCR, 2, 128'hE00, 16'hFFFF);
        axi_read(8'h09, 32'h100, 8'd3, 3'd4, BURST_INCR);
        chk("lit_early_1", got_at(1), 128'hE01);
        chk("lit_early_2", got_at(2), 128'h102);

        // Late wlast (len 1, wlast on beat 4)
        axi_write(8'h0A, 32'h200, 8'd3, 3'd4, BURST_INCR, 4, 128'h200, 16'hFFFF);
        axi_write(8'h0B, 32'h200, 8'd1, 3'd4, BURST_INCR, 4, 128'hF00, 16'hFFFF);
        axi_read(8'h0C, 32'h200, 8'd3, 3'd4, BURST_INCR);
        chk("lit_late_1", got_at(1), 128'hF01);
        chk("lit_late_2", got_at(2), 128'h202);

        // Wrap from last word to word 0
        axi_write(8'h0D, 32'hFFF0, 8'd1, 3'd4, BURST_INCR, 2, 128'hAB0, 16'hFFFF);
        axi_read(8'h0E, 32'hFFF0, 8'd1, 3'd4, BURST_INCR);
        chk("lit_wrap_top", got_at(0), 128'hAB0);
        chk("lit_wrap_zero", got_at(1), 128'hAB1);

        // AW and AR in the same cycle
        fork
            axi_write(8'h0F, 32'h300, 8'd3, 3'd4, BURST_INCR, 4, 128'hC00, 16'hFFFF);
            axi_read(8'h10, 32'h1000, 8'd7, 3'd4, BURST_INCR);
        join
        chk("lit_conc_7", got_at(7), PAT_A + 128'h7);

        // Reset in the middle of a write burst
        @(posedge clk); #1;
        awid = 8'h11; awaddr = 32'h400; awlen = 8'd7; awsize = 3'd4; awburst = BURST_INCR; awvalid = 1;
        wait_hs(0);
        awvalid = 0;
        for (int k = 0; k < 3; k++) begin
            wdata = DW'(k); wstrb = 16'hFFFF; wlast = 0; wvalid = 1;
            wait_hs(1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_awready", DW'(awready), 0);
        chk("arst_wready", DW'(wready), 0);
        chk("arst_bvalid", DW'(bvalid), 0);
        chk("arst_arready_rvalid", DW'({arready, rvalid}), 0);
        wvalid = 0;
        exp_b.delete();
        $display("RESET asserted mid-burst");
        @(posedge clk); #2 rst_n = 1'b1;
        axi_write(8'h12, 32'h500, 8'd1, 3'd4, BURST_INCR, 2, 128'h5500, 16'hFFFF);
        axi_read(8'h13, 32'h500, 8'd1, 3'd4, BURST_INCR);
        chk("lit_after_rst", got_at(1), 128'h5501);

        // Partial strobe write (honoured only with strobes enabled)
        axi_write(8'h14, 32'h600, 8'd0, 3'd4, BURST_INCR, 1, ONES, 16'hFFFF);
        axi_write(8'h15, 32'h600, 8'd0, 3'd4, BURST_INCR, 1, TWOS, 16'h000F);
        axi_read(8'h16, 32'h600, 8'd0, 3'd4, BURST_INCR);
`ifdef AXI4_RAM_SLAVE_STRB_EN
        chk("lit_strb", got_at(0), {ONES[127:32], TWOS[31:0]});
`else
        chk("lit_strb", got_at(0), TWOS);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
